// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture engine.
package la_pkg;

  // Capture FSM states; the encodings are visible on state_o.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } la_state_e;

  // Trigger mode encodings as presented on trig_mode_i.
  localparam logic [1:0] TRIG_HIGH = 2'b00;
  localparam logic [1:0] TRIG_LOW  = 2'b01;
  localparam logic [1:0] TRIG_RISE = 2'b10;
  localparam logic [1:0] TRIG_FALL = 2'b11;

endpackage

// File: rtl/la_capture_core_if.sv
// Probe, control and readout bundle of the capture engine.
interface la_capture_core_if #(
  parameter int DATA_W = 16,
  parameter int TRIG_W = 4,
  parameter int ADDR_W = 8
);
  logic              sample_en_i;
  logic [DATA_W-1:0] data_i;
  logic [TRIG_W-1:0] trig_i;
  logic [TRIG_W-1:0] trig_mask_i;
  logic [1:0]        trig_mode_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic              arm_i;
  logic              abort_i;
  logic [2:0]        state_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_idx_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;

  // Host / probe side: drives samples and control, reads results.
  modport master (
    output sample_en_i, data_i, trig_i, trig_mask_i, trig_mode_i, pretrig_i,
           arm_i, abort_i, rd_addr_i,
    input  state_o, busy_o, done_o, trig_idx_o, rd_data_o
  );

  // Capture engine side.
  modport slave (
    input  sample_en_i, data_i, trig_i, trig_mask_i, trig_mode_i, pretrig_i,
           arm_i, abort_i, rd_addr_i,
    output state_o, busy_o, done_o, trig_idx_o, rd_data_o
  );
endinterface

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
// The storage array has no reset so it maps onto block RAM; only the
// read register is reset.
module la_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, refreshed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample buffer, masked level/edge
// trigger, pre-trigger retention and trigger-relative readout.
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TRIG_W = 4,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  la_capture_core_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  la_state_e         state_r, state_n;
  logic [ADDR_W-1:0] wptr_r, wptr_n;
  logic [ADDR_W-1:0] cnt_r, cnt_n;
  logic [ADDR_W-1:0] trig_ptr_r, trig_ptr_n;
  logic [ADDR_W-1:0] pre_r, pre_n;
  logic [1:0]        mode_r, mode_n;
  logic [TRIG_W-1:0] mask_r, mask_n;
  logic [TRIG_W-1:0] hist_r, hist_n;
  logic              hist_vld_r, hist_vld_n;
  logic              busy_r, done_r;

  logic              we_s;
  logic              hit_s;
  logic [ADDR_W-1:0] cnt_inc_s;
  logic [ADDR_W-1:0] post_len_s;
  logic [ADDR_W-1:0] rd_phys_s;

  assign cnt_inc_s  = cnt_r + ADDR_ONE;
  assign post_len_s = LAST_IDX - pre_r;
  // Logical index 0 is the oldest retained sample; wraps naturally.
  assign rd_phys_s  = trig_ptr_r - pre_r + bus.rd_addr_i;

  // Trigger qualification: every masked bit must satisfy the latched mode;
  // edge modes need a valid previous sample in the history register.
  always_comb begin
    hit_s = 1'b0;
    if (mask_r == {TRIG_W{1'b0}}) begin
      hit_s = 1'b1;
    end else begin
      case (mode_r)
        TRIG_HIGH: hit_s = ((bus.trig_i & mask_r) == mask_r);
        TRIG_LOW:  hit_s = ((~bus.trig_i & mask_r) == mask_r);
        TRIG_RISE: hit_s = hist_vld_r && ((bus.trig_i & ~hist_r & mask_r) == mask_r);
        TRIG_FALL: hit_s = hist_vld_r && ((~bus.trig_i & hist_r & mask_r) == mask_r);
        default:   hit_s = 1'b0;
      endcase
    end
  end

  // Next-state, pointer and configuration-latch logic of the capture FSM.
  always_comb begin
    state_n    = state_r;
    wptr_n     = wptr_r;
    cnt_n      = cnt_r;
    trig_ptr_n = trig_ptr_r;
    pre_n      = pre_r;
    mode_n     = mode_r;
    mask_n     = mask_r;
    hist_n     = hist_r;
    hist_vld_n = hist_vld_r;
    we_s       = 1'b0;
    if (bus.abort_i) begin
      // Abort beats everything, including a simultaneous arm; buffer kept.
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.arm_i) begin
            pre_n      = bus.pretrig_i;
            mode_n     = bus.trig_mode_i;
            mask_n     = bus.trig_mask_i;
            wptr_n     = ADDR_ZERO;
            cnt_n      = ADDR_ZERO;
            hist_vld_n = 1'b0;
            if (bus.pretrig_i == ADDR_ZERO) begin
              state_n = WAIT;
            end else begin
              state_n = PRE;
            end
          end else begin
            state_n = state_r;
          end
        end
        PRE: begin
          if (bus.sample_en_i) begin
            we_s       = 1'b1;
            wptr_n     = wptr_r + ADDR_ONE;
            cnt_n      = cnt_inc_s;
            hist_n     = bus.trig_i;
            hist_vld_n = 1'b1;
            if (cnt_inc_s == pre_r) begin
              state_n = WAIT;
            end else begin
              state_n = PRE;
            end
          end else begin
            state_n = PRE;
          end
        end
        WAIT: begin
          if (bus.sample_en_i) begin
            we_s       = 1'b1;
            wptr_n     = wptr_r + ADDR_ONE;
            hist_n     = bus.trig_i;
            hist_vld_n = 1'b1;
            if (hit_s) begin
              trig_ptr_n = wptr_r;
              cnt_n      = ADDR_ZERO;
              if (pre_r == LAST_IDX) begin
                state_n = DONE;
              end else begin
                state_n = POST;
              end
            end else begin
              state_n = WAIT;
            end
          end else begin
            state_n = WAIT;
          end
        end
        POST: begin
          if (bus.sample_en_i) begin
            we_s   = 1'b1;
            wptr_n = wptr_r + ADDR_ONE;
            cnt_n  = cnt_inc_s;
            if (cnt_inc_s == post_len_s) begin
              state_n = DONE;
            end else begin
              state_n = POST;
            end
          end else begin
            state_n = POST;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Capture state, pointers, latched configuration and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      wptr_r     <= ADDR_ZERO;
      cnt_r      <= ADDR_ZERO;
      trig_ptr_r <= ADDR_ZERO;
      pre_r      <= ADDR_ZERO;
      mode_r     <= 2'b00;
      mask_r     <= {TRIG_W{1'b0}};
      hist_r     <= {TRIG_W{1'b0}};
      hist_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      wptr_r     <= wptr_n;
      cnt_r      <= cnt_n;
      trig_ptr_r <= trig_ptr_n;
      pre_r      <= pre_n;
      mode_r     <= mode_n;
      mask_r     <= mask_n;
      hist_r     <= hist_n;
      hist_vld_r <= hist_vld_n;
      busy_r     <= (state_n == PRE) || (state_n == WAIT) || (state_n == POST);
      done_r     <= (state_n == DONE);
    end
  end

  la_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .we    (we_s),
    .waddr (wptr_r),
    .wdata (bus.data_i),
    .raddr (rd_phys_s),
    .rdata (bus.rd_data_o)
  );

  assign bus.state_o    = state_r;
  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.trig_idx_o = pre_r;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16; data_i carries the
// sample number and sample_en_i pulses every third cycle.
module tb_la_capture_core;
  import la_pkg::*;

  logic clk;
  logic rst_ni;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   smp    = 0;
  int   ph     = 0;
  int   s_first;
  int   chg1, chg2;
  logic [3:0] tv0, tv1, tv2;

  la_capture_core_if #(.DATA_W(16), .TRIG_W(4), .ADDR_W(4)) bus ();

  la_capture_core #(.DATA_W(16), .TRIG_W(4), .DEPTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs for the coming edge, then sample 1 ns after it.
  task automatic step();
    bus.sample_en_i = (ph == 2);
    bus.data_i      = 16'(smp);
    bus.trig_i      = (smp < chg1) ? tv0 : ((smp < chg2) ? tv1 : tv2);
    @(posedge clk);
    if (ph == 2) smp++;
    ph = (ph + 1) % 3;
    #1;
  endtask

  task automatic arm(input logic [1:0] mode, input logic [3:0] mask, input logic [3:0] pre);
    bus.trig_mode_i = mode;
    bus.trig_mask_i = mask;
    bus.pretrig_i   = pre;
    bus.arm_i       = 1'b1;
    step();
    bus.arm_i       = 1'b0;
  endtask

  task automatic run_to(input logic [2:0] st, input string tag);
    int n;
    n = 0;
    while (bus.state_o !== st && n < 400) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.state_o), 32'(st));
  endtask

  task automatic rd(input int addr, input int exp, input string tag);
    bus.rd_addr_i = 4'(addr);
    step();
    chk(tag, 32'(bus.rd_data_o), 32'(exp));
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.sample_en_i = 1'b0; bus.data_i = 16'd0; bus.trig_i = 4'd0;
    bus.trig_mask_i = 4'd0; bus.trig_mode_i = 2'd0; bus.pretrig_i = 4'd0;
    bus.arm_i = 1'b0; bus.abort_i = 1'b0; bus.rd_addr_i = 4'd0;
    chg1 = 1000; chg2 = 1000; tv0 = 4'd0; tv1 = 4'd0; tv2 = 4'd0;
    repeat (3) step();
    chk("rst_state", 32'(bus.state_o), 32'(IDLE));
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_tidx", 32'(bus.trig_idx_o), 32'd0);
    chk("rst_rdata", 32'(bus.rd_data_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // Rising edge on bit 0 at sample 20, pretrig 4.
    smp = 10; chg1 = 20; chg2 = 20; tv0 = 4'b0000; tv1 = 4'b0001; tv2 = 4'b0001;
    arm(TRIG_RISE, 4'b0001, 4'd4);
    chk("a_busy", 32'(bus.busy_o), 32'd1);
    run_to(3'(DONE), "a_done_state");
    chk("a_done_smp", 32'(smp), 32'd32);
    chk("a_done", 32'(bus.done_o), 32'd1);
    chk("a_busy_done", 32'(bus.busy_o), 32'd0);
    chk("a_tidx", 32'(bus.trig_idx_o), 32'd4);
    for (int i = 0; i < 16; i++) rd(i, 16 + i, "a_rd");
    rd(4, 20, "a_rd_trig");

    // Asynchronous reset while in POST.
    chg1 = 1000; chg2 = 1000; tv0 = 4'd0;
    arm(TRIG_HIGH, 4'b0000, 4'd2);
    run_to(3'(POST), "r_in_post");
    #1 rst_ni = 1'b0;
    #1;
    chk("r_state", 32'(bus.state_o), 32'(IDLE));
    chk("r_done", 32'(bus.done_o), 32'd0);
    chk("r_busy", 32'(bus.busy_o), 32'd0);
    chk("r_rdata", 32'(bus.rd_data_o), 32'd0);
    #1 rst_ni = 1'b1;

    // Mask 0, pretrig 0: first sample triggers.
    smp = 100;
    arm(TRIG_HIGH, 4'b0000, 4'd0);
    chk("b_wait", 32'(bus.state_o), 32'(WAIT));
    s_first = smp;
    run_to(3'(DONE), "b_done_state");
    chk("b_done_smp", 32'(smp), 32'(s_first + 16));
    chk("b_tidx", 32'(bus.trig_idx_o), 32'd0);
    rd(0, s_first, "b_rd0");
    rd(15, s_first + 15, "b_rd15");

    // Falling on bits 2:1 at sample 40, pretrig 15 -> DONE on the hit.
    smp = 20; chg1 = 40; chg2 = 40; tv0 = 4'b0110; tv1 = 4'b0000; tv2 = 4'b0000;
    arm(TRIG_FALL, 4'b0110, 4'd15);
    run_to(3'(DONE), "c_done_state");
    chk("c_done_smp", 32'(smp), 32'd41);
    chk("c_tidx", 32'(bus.trig_idx_o), 32'd15);
    rd(15, 40, "c_rd15");
    rd(0, 25, "c_rd0");

    // Rising with input already high: needs low-then-high.
    smp = 50; chg1 = 60; chg2 = 62; tv0 = 4'b0001; tv1 = 4'b0000; tv2 = 4'b0001;
    arm(TRIG_RISE, 4'b0001, 4'd1);
    while (smp < 58) step();
    chk("d_no_trig", 32'(bus.state_o), 32'(WAIT));
    run_to(3'(DONE), "d_done_state");
    chk("d_done_smp", 32'(smp), 32'd77);
    rd(1, 62, "d_rd1");
    rd(0, 61, "d_rd0");

    // Level-low on bit 3.
    smp = 80; chg1 = 85; chg2 = 85; tv0 = 4'b1000; tv1 = 4'b0000; tv2 = 4'b0000;
    arm(TRIG_LOW, 4'b1000, 4'd2);
    run_to(3'(DONE), "e_done_state");
    chk("e_done_smp", 32'(smp), 32'd99);
    rd(2, 85, "e_rd2");
    rd(0, 83, "e_rd0");

    // Abort with simultaneous arm while in WAIT.
    chg1 = 1000; chg2 = 1000; tv0 = 4'd0;
    arm(TRIG_HIGH, 4'b0001, 4'd1);
    run_to(3'(WAIT), "f_wait");
    bus.abort_i = 1'b1; bus.arm_i = 1'b1;
    step();
    bus.abort_i = 1'b0; bus.arm_i = 1'b0;
    chk("f_abort_state", 32'(bus.state_o), 32'(IDLE));
    chk("f_abort_busy", 32'(bus.busy_o), 32'd0);
    chk("f_abort_done", 32'(bus.done_o), 32'd0);
    step();
    chk("f_idle_hold", 32'(bus.state_o), 32'(IDLE));

    // Arm during POST is ignored.
    smp = 200;
    arm(TRIG_HIGH, 4'b0000, 4'd3);
    s_first = smp;
    run_to(3'(POST), "g_post");
    arm(TRIG_RISE, 4'b0001, 4'd7);
    chk("g_arm_ign", 32'(bus.state_o), 32'(POST));
    run_to(3'(DONE), "g_done_state");
    chk("g_done_smp", 32'(smp), 32'(s_first + 16));
    chk("g_tidx", 32'(bus.trig_idx_o), 32'd3);
    rd(3, s_first + 3, "g_rd3");
    rd(0, s_first, "g_rd0");

    // Re-arm from DONE.
    arm(TRIG_HIGH, 4'b0000, 4'd0);
    chk("h_state", 32'(bus.state_o), 32'(WAIT));
    chk("h_busy", 32'(bus.busy_o), 32'd1);
    chk("h_done", 32'(bus.done_o), 32'd0);
    s_first = smp;
    run_to(3'(DONE), "h_done_state");
    chk("h_done_smp", 32'(smp), 32'(s_first + 16));
    rd(0, s_first, "h_rd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
